// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I function codes, control FSM states and datapath select encodings
package riscv_pkg;

   localparam int unsigned F_LUI    = 0;
   localparam int unsigned F_AUIPC  = 1;
   localparam int unsigned F_JAL    = 2;
   localparam int unsigned F_JALR   = 3;
   localparam int unsigned F_BEQ    = 4;
   localparam int unsigned F_BNE    = 5;
   localparam int unsigned F_BLT    = 6;
   localparam int unsigned F_BGE    = 7;
   localparam int unsigned F_BLTU   = 8;
   localparam int unsigned F_BGEU   = 9;
   localparam int unsigned F_LB     = 10;
   localparam int unsigned F_LH     = 11;
   localparam int unsigned F_LW     = 12;
   localparam int unsigned F_LBU    = 13;
   localparam int unsigned F_LHU    = 14;
   localparam int unsigned F_SB     = 15;
   localparam int unsigned F_SH     = 16;
   localparam int unsigned F_SW     = 17;
   localparam int unsigned F_ADDI   = 18;
   localparam int unsigned F_SLTI   = 19;
   localparam int unsigned F_SLTIU  = 20;
   localparam int unsigned F_XORI   = 21;
   localparam int unsigned F_ORI    = 22;
   localparam int unsigned F_ANDI   = 23;
   localparam int unsigned F_SLLI   = 24;
   localparam int unsigned F_SRLI   = 25;
   localparam int unsigned F_SRAI   = 26;
   localparam int unsigned F_ADD    = 27;
   localparam int unsigned F_SUB    = 28;
   localparam int unsigned F_SLL    = 29;
   localparam int unsigned F_SLT    = 30;
   localparam int unsigned F_SLTU   = 31;
   localparam int unsigned F_XOR    = 32;
   localparam int unsigned F_SRL    = 33;
   localparam int unsigned F_SRA    = 34;
   localparam int unsigned F_OR     = 35;
   localparam int unsigned F_AND    = 36;
   localparam int unsigned F_FENCE  = 37;
   localparam int unsigned F_ECALL  = 38;
   localparam int unsigned F_EBREAK = 39;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEM       = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5
   } ctrl_state_t;

   localparam logic [1:0] PC_SEL_PC4  = 2'd0;
   localparam logic [1:0] PC_SEL_IMM  = 2'd1;
   localparam logic [1:0] PC_SEL_JALR = 2'd2;

   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_LOAD = 2'd1;
   localparam logic [1:0] WB_SEL_PC4  = 2'd2;
   localparam logic [1:0] WB_SEL_IMM  = 2'd3;

   localparam logic [1:0] DMEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] DMEM_SIZE_HALF = 2'd1;
   localparam logic [1:0] DMEM_SIZE_WORD = 2'd2;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ECALL   = 2'd1;
   localparam logic [1:0] CAUSE_EBREAK  = 2'd2;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd3;

   function automatic logic is_branch(input int unsigned code);
      return (code >= F_BEQ) && (code <= F_BGEU);
   endfunction

   function automatic logic is_load(input int unsigned code);
      return (code >= F_LB) && (code <= F_LHU);
   endfunction

   function automatic logic is_store(input int unsigned code);
      return (code >= F_SB) && (code <= F_SW);
   endfunction

   function automatic logic [1:0] dmem_size_of(input int unsigned code);
      logic [1:0] size;
      size = DMEM_SIZE_BYTE;
      if (code == F_LH || code == F_LHU || code == F_SH) size = DMEM_SIZE_HALF;
      if (code == F_LW || code == F_SW) size = DMEM_SIZE_WORD;
      return size;
   endfunction

   function automatic logic is_unsigned_load(input int unsigned code);
      return (code == F_LBU) || (code == F_LHU);
   endfunction

   // Branches, stores and FENCE retire without touching the register file.
   function automatic logic rf_we_of(input int unsigned code);
      return (code <= F_JALR) || is_load(code) || ((code >= F_ADDI) && (code <= F_AND));
   endfunction

   function automatic logic [1:0] wb_sel_of(input int unsigned code);
      logic [1:0] sel;
      sel = WB_SEL_ALU;
      if (code == F_LUI) sel = WB_SEL_IMM;
      if (code == F_JAL || code == F_JALR) sel = WB_SEL_PC4;
      if (is_load(code)) sel = WB_SEL_LOAD;
      return sel;
   endfunction

   function automatic logic [1:0] pc_sel_of(input int unsigned code, input logic taken);
      logic [1:0] sel;
      sel = PC_SEL_PC4;
      if (code == F_JAL || (is_branch(code) && taken)) sel = PC_SEL_IMM;
      if (code == F_JALR) sel = PC_SEL_JALR;
      return sel;
   endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// rtl/riscv_multicycle_ctrl_if.sv - instruction and data memory request/ready handshakes
interface riscv_multicycle_ctrl_if;
   logic       imem_req_o;
   logic       imem_ready_i;
   logic       dmem_req_o;
   logic       dmem_we_o;
   logic [1:0] dmem_size_o;
   logic       dmem_unsigned_o;
   logic       dmem_ready_i;

   modport master (
      output imem_req_o, dmem_req_o, dmem_we_o, dmem_size_o, dmem_unsigned_o,
      input  imem_ready_i, dmem_ready_i
   );

   modport slave (
      input  imem_req_o, dmem_req_o, dmem_we_o, dmem_size_o, dmem_unsigned_o,
      output imem_ready_i, dmem_ready_i
   );
endinterface

// File: rtl/riscv_perf_counters.sv
// rtl/riscv_perf_counters.sv - free-running cycle and retired-instruction counters
module riscv_perf_counters #(
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cycle_en_i,
   input  logic                 instret_en_i,
   output logic [CNT_WIDTH-1:0] cycle_cnt_o,
   output logic [CNT_WIDTH-1:0] instret_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cycle_cnt_o <= '0;
         instret_o   <= '0;
      end else begin
         if (cycle_en_i)   cycle_cnt_o <= cycle_cnt_o + CNT_WIDTH'(1);
         if (instret_en_i) instret_o   <= instret_o + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// rtl/riscv_multicycle_ctrl.sv - RV32I multi-cycle control FSM; counters built only with RISCV_CTRL_PERF_CNT_EN
module riscv_multicycle_ctrl
   import riscv_pkg::*;
#(
   parameter int F_WIDTH   = 6,
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [F_WIDTH-1:0]   f_i,
   input  logic                 branch_taken_i,
   riscv_multicycle_ctrl_if.master mem,
   output logic                 ir_we_o,
   output logic                 pc_we_o,
   output logic [1:0]           pc_sel_o,
   output logic                 rf_we_o,
   output logic [1:0]           wb_sel_o,
   output logic                 halt_o,
   output logic [1:0]           cause_o,
   output logic [CNT_WIDTH-1:0] cycle_cnt_o,
   output logic [CNT_WIDTH-1:0] instret_o
);

   ctrl_state_t        state_q, state_d;
   logic [F_WIDTH-1:0] f_q;
   logic               taken_q;
   logic [1:0]         cause_q, cause_d;
   int unsigned        code_i, code_q;

   assign code_i = 32'(f_i);
   assign code_q = 32'(f_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_FETCH;
         f_q     <= '0;
         taken_q <= 1'b0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         if (state_q == ST_DECODE)  f_q <= f_i;
         if (state_q == ST_EXECUTE) taken_q <= branch_taken_i && is_branch(code_q);
      end
   end

   always_comb begin
      state_d             = state_q;
      cause_d             = cause_q;
      mem.imem_req_o      = 1'b0;
      mem.dmem_req_o      = 1'b0;
      mem.dmem_we_o       = 1'b0;
      mem.dmem_size_o     = DMEM_SIZE_BYTE;
      mem.dmem_unsigned_o = 1'b0;
      ir_we_o             = 1'b0;
      pc_we_o             = 1'b0;
      pc_sel_o            = PC_SEL_PC4;
      rf_we_o             = 1'b0;
      wb_sel_o            = WB_SEL_ALU;

      unique case (state_q)
         ST_FETCH: begin
            mem.imem_req_o = 1'b1;
            // The IR must not latch while reset holds the FSM in FETCH.
            if (mem.imem_ready_i && !rst_i) begin
               ir_we_o = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (code_i == F_ECALL) begin
               state_d = ST_HALT;
               cause_d = CAUSE_ECALL;
            end else if (code_i == F_EBREAK) begin
               state_d = ST_HALT;
               cause_d = CAUSE_EBREAK;
            end else if (code_i > F_EBREAK) begin
               state_d = ST_HALT;
               cause_d = CAUSE_ILLEGAL;
            end else begin
               state_d = ST_EXECUTE;
            end
         end
         ST_EXECUTE: begin
            state_d = (is_load(code_q) || is_store(code_q)) ? ST_MEM : ST_WRITEBACK;
         end
         ST_MEM: begin
            mem.dmem_req_o      = 1'b1;
            mem.dmem_we_o       = is_store(code_q);
            mem.dmem_size_o     = dmem_size_of(code_q);
            mem.dmem_unsigned_o = is_unsigned_load(code_q);
            if (mem.dmem_ready_i) state_d = ST_WRITEBACK;
         end
         ST_WRITEBACK: begin
            pc_we_o  = 1'b1;
            pc_sel_o = pc_sel_of(code_q, taken_q);
            rf_we_o  = rf_we_of(code_q);
            wb_sel_o = wb_sel_of(code_q);
            state_d  = ST_FETCH;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   assign halt_o  = (state_q == ST_HALT);
   assign cause_o = cause_q;

`ifdef RISCV_CTRL_PERF_CNT_EN
   riscv_perf_counters #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_perf_counters (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cycle_en_i   (state_q != ST_HALT),
      .instret_en_i (state_q == ST_WRITEBACK),
      .cycle_cnt_o  (cycle_cnt_o),
      .instret_o    (instret_o)
   );
`else
   assign cycle_cnt_o = '0;
   assign instret_o   = '0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb/tb_riscv_multicycle_ctrl.sv - directed self-checking bench for riscv_multicycle_ctrl
module tb_riscv_multicycle_ctrl;

`ifdef RISCV_CTRL_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic       imem_req;
      logic       ir_we;
      logic       dmem_req;
      logic       dmem_we;
      logic [1:0] size;
      logic       uns;
      logic       pc_we;
      logic [1:0] pc_sel;
      logic       rf_we;
      logic [1:0] wb_sel;
      logic       halt;
      logic [1:0] cause;
   } out_t;

   typedef struct packed {
      logic [5:0] f;
      logic       taken;
      logic       imem_ready;
      logic       dmem_ready;
   } in_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  f = '0;
   logic        taken = 1'b0;
   logic        ir_we, pc_we, rf_we, halt;
   logic [1:0]  pc_sel, wb_sel, cause;
   logic [63:0] cycle_cnt, instret;

   int checks = 0;
   int failures = 0;
   out_t exp_q[$];
   in_t  in_q[$];
   longint unsigned cyc_m = 0, ins_m = 0;
   int wb_idx, halt_idx, dreq_cnt;

   riscv_multicycle_ctrl_if mem_bus ();

   riscv_multicycle_ctrl #(.F_WIDTH(6), .CNT_WIDTH(64)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .f_i            (f),
      .branch_taken_i (taken),
      .mem            (mem_bus),
      .ir_we_o        (ir_we),
      .pc_we_o        (pc_we),
      .pc_sel_o       (pc_sel),
      .rf_we_o        (rf_we),
      .wb_sel_o       (wb_sel),
      .halt_o         (halt),
      .cause_o        (cause),
      .cycle_cnt_o    (cycle_cnt),
      .instret_o      (instret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic out_t dut_out();
      out_t o;
      o.imem_req = mem_bus.imem_req_o;  o.ir_we = ir_we;
      o.dmem_req = mem_bus.dmem_req_o;  o.dmem_we = mem_bus.dmem_we_o;
      o.size = mem_bus.dmem_size_o;     o.uns = mem_bus.dmem_unsigned_o;
      o.pc_we = pc_we;  o.pc_sel = pc_sel;  o.rf_we = rf_we;  o.wb_sel = wb_sel;
      o.halt = halt;    o.cause = cause;
      return o;
   endfunction

   // Reference behaviour: the per-cycle output sequence one instruction must produce.
   task automatic build(input int c, input bit tk, input int iw, input int dw, input int nhalt);
      out_t o;
      in_t  i;
      bit   is_mem;
      for (int k = 0; k <= iw; k++) begin
         o = '0; o.imem_req = 1'b1; o.ir_we = (k == iw);
         i = '{f: 6'h3F, taken: ~tk, imem_ready: (k == iw), dmem_ready: 1'b1};
         exp_q.push_back(o); in_q.push_back(i);
      end
      exp_q.push_back('0);
      in_q.push_back('{f: 6'(c), taken: ~tk, imem_ready: 1'b1, dmem_ready: 1'b1});
      if (c >= 38) begin
         for (int k = 0; k < nhalt; k++) begin
            o = '0; o.halt = 1'b1;
            o.cause = (c == 38) ? 2'd1 : (c == 39) ? 2'd2 : 2'd3;
            exp_q.push_back(o);
            in_q.push_back('{f: 6'd0, taken: 1'b1, imem_ready: 1'b1, dmem_ready: 1'b1});
         end
         return;
      end
      exp_q.push_back('0);
      in_q.push_back('{f: 6'h3F, taken: tk, imem_ready: 1'b1, dmem_ready: 1'b1});
      is_mem = (c >= 10 && c <= 17);
      if (is_mem) begin
         for (int k = 0; k <= dw; k++) begin
            o = '0; o.dmem_req = 1'b1;
            o.dmem_we = (c >= 15);
            case (c) inside
               11, 14, 16: o.size = 2'd1;
               12, 17:     o.size = 2'd2;
               default:    o.size = 2'd0;
            endcase
            o.uns = (c == 13 || c == 14);
            exp_q.push_back(o);
            in_q.push_back('{f: 6'h3F, taken: ~tk, imem_ready: 1'b1, dmem_ready: (k == dw)});
         end
      end
      o = '0; o.pc_we = 1'b1;
      case (c) inside
         0:        begin o.rf_we = 1'b1; o.wb_sel = 2'd3; end
         1:        o.rf_we = 1'b1;
         2:        begin o.rf_we = 1'b1; o.wb_sel = 2'd2; o.pc_sel = 2'd1; end
         3:        begin o.rf_we = 1'b1; o.wb_sel = 2'd2; o.pc_sel = 2'd2; end
         [4:9]:    o.pc_sel = tk ? 2'd1 : 2'd0;
         [10:14]:  begin o.rf_we = 1'b1; o.wb_sel = 2'd1; end
         [15:17]:  o.rf_we = 1'b0;
         37:       o.rf_we = 1'b0;
         default:  o.rf_we = 1'b1;
      endcase
      exp_q.push_back(o);
      in_q.push_back('{f: 6'h3F, taken: ~tk, imem_ready: 1'b1, dmem_ready: 1'b1});
   endtask

   // Entered and left at posedge+1; n<0 plays the whole queue.
   task automatic play(input string name, input int n);
      int   idx;
      out_t e, a;
      in_t  i;
      idx = 0; wb_idx = 0; halt_idx = 0; dreq_cnt = 0;
      while (exp_q.size() > 0 && (n < 0 || idx < n)) begin
         e = exp_q.pop_front();
         i = in_q.pop_front();
         idx++;
         f = i.f; taken = i.taken;
         mem_bus.imem_ready_i = i.imem_ready;
         mem_bus.dmem_ready_i = i.dmem_ready;
         @(negedge clk);
         a = dut_out();
         chk($sformatf("%s c%0d outs", name, idx), 64'(a), 64'(e));
         chk($sformatf("%s c%0d cycle_cnt", name, idx), cycle_cnt, PERF ? 64'(cyc_m) : 64'd0);
         chk($sformatf("%s c%0d instret", name, idx), instret, PERF ? 64'(ins_m) : 64'd0);
         if (a.pc_we && wb_idx == 0) wb_idx = idx;
         if (a.halt && halt_idx == 0) halt_idx = idx;
         if (a.dmem_req) dreq_cnt++;
         if (!e.halt) cyc_m++;
         if (e.pc_we) ins_m++;
         @(posedge clk); #1;
      end
      exp_q.delete(); in_q.delete();
   endtask

   task automatic do_reset(input string name, input bit first_check);
      rst = 1'b1; f = '0; taken = 1'b0;
      mem_bus.imem_ready_i = 1'b0; mem_bus.dmem_ready_i = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      if (first_check) begin
         out_t e;
         e = '0; e.imem_req = 1'b1;
         chk({name, " reset outs"}, 64'(dut_out()), 64'(e));
         chk({name, " reset dmem_req"}, 64'(mem_bus.dmem_req_o), 64'd0);
         chk({name, " reset cycle_cnt"}, cycle_cnt, 64'd0);
         chk({name, " reset instret"}, instret, 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      cyc_m = 0; ins_m = 0;
   endtask

   initial begin
      mem_bus.imem_ready_i = 1'b0;
      mem_bus.dmem_ready_i = 1'b0;
      @(posedge clk); #1;
      do_reset("init", 1'b1);

      build(18, 1'b0, 0, 0, 0); play("addi", -1);
      chk("addi wb cycle", 64'(wb_idx), 64'd4);
      chk("addi instret after", instret, PERF ? 64'd1 : 64'd0);

      build(14, 1'b0, 0, 3, 0); play("lhu", -1);
      chk("lhu wb cycle", 64'(wb_idx), 64'd8);
      chk("lhu dmem_req cycles", 64'(dreq_cnt), 64'd4);

      build(4, 1'b1, 0, 0, 0);  play("beq_t", -1);
      build(4, 1'b0, 0, 0, 0);  play("beq_nt", -1);
      build(9, 1'b1, 1, 0, 0);  play("bgeu_t", -1);
      build(3, 1'b0, 0, 0, 0);  play("jalr", -1);
      build(17, 1'b0, 0, 0, 0); play("sw", -1);
      chk("sw wb cycle", 64'(wb_idx), 64'd5);
      build(2, 1'b0, 0, 0, 0);  play("jal", -1);
      build(0, 1'b0, 0, 0, 0);  play("lui", -1);
      build(1, 1'b0, 0, 0, 0);  play("auipc", -1);
      build(37, 1'b0, 0, 0, 0); play("fence", -1);
      build(10, 1'b0, 2, 1, 0); play("lb", -1);
      chk("lb wb cycle", 64'(wb_idx), 64'd8);
      build(15, 1'b0, 0, 0, 0); play("sb", -1);
      build(13, 1'b0, 0, 2, 0); play("lbu", -1);
      build(36, 1'b0, 0, 0, 0); play("and", -1);

      build(12, 1'b0, 0, 5, 0); play("lw_abort", 5);
      do_reset("mid_mem", 1'b1);

      build(39, 1'b0, 0, 0, 100); play("ebreak", -1);
      chk("ebreak halt cycle", 64'(halt_idx), 64'd3);
      do_reset("after_ebreak", 1'b1);
      build(38, 1'b0, 0, 0, 5); play("ecall", -1);
      do_reset("after_ecall", 1'b0);
      build(50, 1'b0, 0, 0, 5); play("illegal", -1);
      chk("illegal cause", 64'(cause), 64'd3);
      do_reset("after_illegal", 1'b1);
      build(27, 1'b0, 0, 0, 0); play("add_post", -1);
      chk("add_post wb cycle", 64'(wb_idx), 64'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multi-cycle control FSM for the RV32I core. It consumes the 6-bit function code produced by the instruction decoder and sequences fetch, decode, execute, memory and writeback across the shared ALU, register file, PC register and memory ports. It owns the instruction/data memory request handshakes, emits all datapath write enables and mux selects, and halts the core on ECALL, EBREAK or an illegal code.

## Interface
- F_WIDTH, 6, width of decoder function code
- CNT_WIDTH, 64, width of performance counters
- clk_i  in  1  core clock
- rst_i  in  1  synchronous, active-high reset
- f_i  in  F_WIDTH  decoder function code (0 = LUI … 39 = EBREAK)
- branch_taken_i  in  1  ALU compare result; valid in EXECUTE
- imem_req_o  out  1  instruction fetch request
- imem_ready_i  in  1  fetch data valid this cycle
- dmem_req_o  out  1  data access request
- dmem_we_o  out  1  1 = store
- dmem_size_o  out  2  0 = byte, 1 = half, 2 = word
- dmem_unsigned_o  out  1  zero-extend load data (LBU, LHU)
- dmem_ready_i  in  1  data access complete this cycle
- ir_we_o  out  1  latch instruction register
- pc_we_o  out  1  update PC
- pc_sel_o  out  2  0 = pc+4, 1 = pc+imm (taken branch, JAL), 2 = (rs1+imm)&~1 (JALR)
- rf_we_o  out  1  register file write
- wb_sel_o  out  2  0 = ALU, 1 = load data, 2 = pc+4, 3 = imm (LUI)
- halt_o  out  1  core halted
- cause_o  out  2  0 = none, 1 = ECALL, 2 = EBREAK, 3 = illegal
- cycle_cnt_o  out  CNT_WIDTH  cycles since reset
- instret_o  out  CNT_WIDTH  retired instructions

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- FETCH: hold imem_req_o=1 until imem_ready_i. In the ready cycle pulse ir_we_o, then go to DECODE.
- DECODE: register f_i into f_q. Branch on f_q:
  - f_q 38 → HALT, cause 1.
  - f_q 39 → HALT, cause 2.
  - f_q > 39 → HALT, cause 3.
  - Otherwise → EXECUTE.
- EXECUTE: ALU operates. For branches (4–9), register branch_taken_i into taken_q.
  - Loads (10–14) and stores (15–17) → MEM.
  - All others → WRITEBACK.
- MEM: hold dmem_req_o=1 with dmem_we_o, dmem_size_o and dmem_unsigned_o stable until dmem_ready_i, then go to WRITEBACK.
  - Size mapping: LB/LBU/SB = 0; LH/LHU/SH = 1; LW/SW = 2.
- WRITEBACK: pc_we_o=1 for exactly one cycle, then → FETCH.
  - pc_sel: 1 for JAL or a taken branch; 2 for JALR; 0 otherwise.
  - rf_we_o=1 for codes 0–3, 10–14 and 18–36; 0 for branches, stores and FENCE (37).
  - wb_sel: LUI = 3; JAL/JALR = 2; loads = 1; else 0. AUIPC uses wb_sel 0, with the ALU computing pc+imm.
- FENCE (37) executes as a NOP: pc+4, no write.
- HALT is absorbing. halt_o=1, cause_o held, all other request and enable outputs 0. Only rst_i exits HALT.
- Selects and enables are asserted only in their stated state; they are 0 in all other states.

## Timing
- Reset: state=FETCH. Every output is 0 except imem_req_o, which is 1 in the first cycle after reset deasserts.
- Latency with zero-wait memory (ready in the request cycle):
  - ALU op, branch, jump, LUI/AUIPC, FENCE: 4 cycles.
  - Load or store: 5 cycles.
  - Each wait cycle on a memory port adds 1 cycle.
- Requests stay asserted with stable attributes until ready; a ready seen while req=0 is ignored.
- Reset mid-access drops req at the next edge. The memory side must tolerate an abandoned request.
- branch_taken_i is sampled only in EXECUTE.
- f_i is sampled only in DECODE, one cycle after ir_we_o.

## Configuration
- RISCV_CTRL_PERF_CNT_EN defined:
  - cycle_cnt_o increments every cycle not in reset.
  - instret_o increments in each WRITEBACK cycle.
  - Both reset to 0 and wrap modulo 2^CNT_WIDTH. Both freeze in HALT.
- Undefined: both ports remain present, tied to 0, with no counter flops.

## Structure
- Package riscv_pkg holds:
  - the F_* function-code constants (F_LUI=0 … F_EBREAK=39), shared with the decoder;
  - the ctrl_state_t enum;
  - the PC_SEL_*, WB_SEL_*, DMEM_SIZE_* and CAUSE_* constants.
- One sub-module, riscv_perf_counters, holds the two counters. It is instantiated only under RISCV_CTRL_PERF_CNT_EN.

## Test plan
- ADDI (f=18), ready tied high → ir_we at cycle 1, pc_we=1, pc_sel=0, rf_we=1, wb_sel=0 at cycle 4; instret=1.
- LHU (f=14), dmem_ready delayed 3 cycles → dmem_req held 4 cycles with size=1, unsigned=1; WRITEBACK at cycle 8 with wb_sel=1, rf_we=1.
- BEQ (f=4): branch_taken_i=1 → pc_sel=1, rf_we=0; branch_taken_i=0 → pc_sel=0.
- JALR (f=3) → pc_sel=2, wb_sel=2, rf_we=1. SW (f=17) → dmem_we=1, size=2, rf_we=0 in WRITEBACK.
- EBREAK (f=39) → halt_o=1, cause_o=2 from cycle 3 and held for 100 cycles, imem_req=0; rst_i returns state to FETCH.
- f=50 → cause_o=3. rst_i asserted mid-MEM → dmem_req=0 next cycle and all counters 0.
